// File: rtl/paddle_ctrl.sv
// paddle_ctrl: multi-paddle horizontal position controller.
// Holds every paddle at x_init until the first move request, then moves each
// paddle independently on every tick. A paddle speeds up the longer its
// direction is held, and its position is always clamped to the screen.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   tick                  one-cycle movement strobe (frame rate)
//   pause                 level; freezes motion while high
//   screen_width          screen width in pixels
//   paddle_width, x_init  per-paddle width / start x, paddle i at [i*X_W +: X_W]
//   move_left/move_right  per-paddle direction requests (level)
//   x_pos                 registered paddle left-edge positions (same packing)
//   started               high once the game has left IDLE
//   at_left/at_right      registered per-paddle limit flags
//
// state  | meaning
// IDLE   | positions track x_init, waiting for a tick with a move request
// RUN    | paddles move on every tick
// PAUSED | positions frozen, speed ramps reset
module paddle_ctrl #(
  parameter int X_W         = 10,
  parameter int N_PAD       = 2,
  parameter int MAX_SPEED   = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   pause,
  input  logic [X_W-1:0]         screen_width,
  input  logic [N_PAD*X_W-1:0]   paddle_width,
  input  logic [N_PAD*X_W-1:0]   x_init,
  input  logic [N_PAD-1:0]       move_left,
  input  logic [N_PAD-1:0]       move_right,
  output logic [N_PAD*X_W-1:0]   x_pos,
  output logic                   started,
  output logic [N_PAD-1:0]       at_left,
  output logic [N_PAD-1:0]       at_right
);

  localparam int SP_W = $clog2(MAX_SPEED + 1);
  localparam int HC_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [SP_W-1:0] SPEED_ONE = SP_W'(1);
  localparam logic [SP_W-1:0] SPEED_MAX = SP_W'(MAX_SPEED);
  localparam logic [HC_W-1:0] HOLD_TC   = HC_W'(ACCEL_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

  state_t state_q, state_d;

  logic [X_W-1:0]  x_q       [N_PAD];
  logic [X_W-1:0]  x_d       [N_PAD];
  logic [X_W-1:0]  right_lim [N_PAD];
  logic [X_W-1:0]  left_x    [N_PAD];
  logic [X_W-1:0]  right_x   [N_PAD];
  logic [X_W:0]    sum_ext   [N_PAD];
  logic [SP_W-1:0] step      [N_PAD];
  logic [SP_W-1:0] speed_q   [N_PAD];
  logic [SP_W-1:0] speed_d   [N_PAD];
  logic [HC_W-1:0] hold_q    [N_PAD];
  logic [HC_W-1:0] hold_d    [N_PAD];
  dir_t            dir_q     [N_PAD];
  dir_t            dir_d     [N_PAD];
  dir_t            cur_dir   [N_PAD];
  logic [N_PAD-1:0] at_left_d, at_right_d;
  logic             start_go;

  assign start_go = tick & ~pause & (|(move_left | move_right));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = RUN;
      RUN:     if (pause)    state_d = PAUSED;
      PAUSED:  if (!pause)   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Per-paddle limits and clamped candidate positions for both directions.
  // A direction change always moves by exactly one pixel.
  always_comb begin
    for (int i = 0; i < N_PAD; i++) begin
      if (paddle_width[i*X_W +: X_W] >= screen_width)
        right_lim[i] = '0;
      else
        right_lim[i] = screen_width - paddle_width[i*X_W +: X_W];

      cur_dir[i] = DIR_NONE;
      if (move_left[i] && !move_right[i])
        cur_dir[i] = DIR_L;
      else if (move_right[i] && !move_left[i])
        cur_dir[i] = DIR_R;

      step[i] = (cur_dir[i] != dir_q[i]) ? SPEED_ONE : speed_q[i];

      if ({1'b0, x_q[i]} < (X_W+1)'(step[i]))
        left_x[i] = '0;
      else
        left_x[i] = x_q[i] - X_W'(step[i]);

      sum_ext[i] = {1'b0, x_q[i]} + (X_W+1)'(step[i]);
      if (sum_ext[i] > {1'b0, right_lim[i]})
        right_x[i] = right_lim[i];
      else
        right_x[i] = sum_ext[i][X_W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < N_PAD; i++) begin
      x_d[i]        = x_q[i];
      speed_d[i]    = speed_q[i];
      hold_d[i]     = hold_q[i];
      dir_d[i]      = dir_q[i];
      at_left_d[i]  = at_left[i];
      at_right_d[i] = at_right[i];
      case (state_q)
        IDLE: begin
          x_d[i]        = x_init[i*X_W +: X_W];
          at_left_d[i]  = (x_d[i] == '0);
          at_right_d[i] = (x_d[i] == right_lim[i]);
          // The start tick records the requested direction so that holding
          // the same button afterwards continues the ramp rather than restarting.
          if (start_go) dir_d[i] = cur_dir[i];
        end
        RUN: begin
          if (pause) begin
            speed_d[i] = SPEED_ONE;
            hold_d[i]  = '0;
          end else if (tick) begin
            dir_d[i] = cur_dir[i];
            case (cur_dir[i])
              DIR_L:   x_d[i] = left_x[i];
              DIR_R:   x_d[i] = right_x[i];
              default: x_d[i] = x_q[i];
            endcase
            if (cur_dir[i] == DIR_NONE || cur_dir[i] != dir_q[i]) begin
              speed_d[i] = SPEED_ONE;
              hold_d[i]  = '0;
            end else if (hold_q[i] + HC_W'(1) == HOLD_TC) begin
              hold_d[i] = '0;
              if (speed_q[i] != SPEED_MAX) speed_d[i] = speed_q[i] + SP_W'(1);
            end else begin
              hold_d[i] = hold_q[i] + HC_W'(1);
            end
            at_left_d[i]  = (x_d[i] == '0);
            at_right_d[i] = (x_d[i] == right_lim[i]);
          end
        end
        PAUSED: begin
          speed_d[i] = SPEED_ONE;
          hold_d[i]  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      started  <= 1'b0;
      at_left  <= '0;
      at_right <= '0;
      for (int i = 0; i < N_PAD; i++) begin
        x_q[i]     <= x_init[i*X_W +: X_W];
        speed_q[i] <= SPEED_ONE;
        hold_q[i]  <= '0;
        dir_q[i]   <= DIR_NONE;
      end
    end else begin
      state_q  <= state_d;
      // FSM never returns to IDLE without reset, so this is sticky.
      started  <= (state_d != IDLE);
      at_left  <= at_left_d;
      at_right <= at_right_d;
      for (int i = 0; i < N_PAD; i++) begin
        x_q[i]     <= x_d[i];
        speed_q[i] <= speed_d[i];
        hold_q[i]  <= hold_d[i];
        dir_q[i]   <= dir_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_PAD; g++) begin : g_pack
    assign x_pos[g*X_W +: X_W] = x_q[g];
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl (default parameters: X_W=10, N_PAD=2,
// MAX_SPEED=4, ACCEL_TICKS=8). Stimulus pushes the hand-computed expected
// outputs for the next clock edge; a monitor pops and compares after it.
module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        reset, tick, pause;
  logic [9:0]  screen_width;
  logic [19:0] paddle_width, x_init, x_pos;
  logic [1:0]  move_left, move_right, at_left, at_right;
  logic        started;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic       st;
    logic [1:0] al;
    logic [1:0] ar;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  exp_t  e;
  string nm;
  int    n_checks = 0;
  int    n_fail   = 0;

  paddle_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause),
    .screen_width(screen_width), .paddle_width(paddle_width), .x_init(x_init),
    .move_left(move_left), .move_right(move_right),
    .x_pos(x_pos), .started(started), .at_left(at_left), .at_right(at_right)
  );

  always #5 clk = ~clk;

  // Monitor: outputs settle 1 time unit after the edge the expectation targets.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      n_checks++;
      if (x_pos !== {e.x1, e.x0} || started !== e.st ||
          at_left !== e.al || at_right !== e.ar) begin
        n_fail++;
        $display("FAIL %s: got x0=%0d x1=%0d started=%0b at_left=%b at_right=%b, expected x0=%0d x1=%0d started=%0b at_left=%b at_right=%b",
                 nm, x_pos[9:0], x_pos[19:10], started, at_left, at_right,
                 e.x0, e.x1, e.st, e.al, e.ar);
      end
    end
  end

  // Called at a negedge: drive tick, queue the expectation for the next edge,
  // then leave one idle cycle so tick stays a single-cycle pulse.
  task automatic step(input bit tk, input string name, input int x0, input int x1,
                      input bit st, input bit [1:0] al, input bit [1:0] ar);
    exp_t item;
    item.x0 = 10'(x0);
    item.x1 = 10'(x1);
    item.st = st;
    item.al = al;
    item.ar = ar;
    tick = tk;
    sb_q.push_back(item);
    nm_q.push_back(name);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int x0, x1, d;
    reset = 1'b1; tick = 1'b0; pause = 1'b0;
    screen_width = 10'd640;
    paddle_width = {10'd64, 10'd64};
    x_init       = {10'd100, 10'd288};
    move_left = 2'b00; move_right = 2'b00;
    @(negedge clk);

    // Game 1: start gating, ramp, direction changes, pause.
    step(0, "reset", 288, 100, 0, 2'b00, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1, "idle_hold", 288, 100, 0, 2'b00, 2'b00);
    pause = 1'b1; move_right = 2'b01;
    step(1, "pause_blocks_start", 288, 100, 0, 2'b00, 2'b00);
    pause = 1'b0;
    step(1, "start", 288, 100, 1, 2'b00, 2'b00);

    x0 = 288;
    for (int k = 0; k < 28; k++) begin
      d = (k < 8) ? 1 : (k < 16) ? 2 : (k < 24) ? 3 : 4;
      x0 += d;
      step(1, "ramp", x0, 100, 1, 2'b00, 2'b00);
    end
    move_right = 2'b00;
    step(1, "release", 352, 100, 1, 2'b00, 2'b00);
    move_right = 2'b01;
    step(1, "restart_dir", 353, 100, 1, 2'b00, 2'b00);
    step(1, "hold_after_restart", 354, 100, 1, 2'b00, 2'b00);
    move_left = 2'b01;
    step(1, "conflict", 354, 100, 1, 2'b00, 2'b00);
    move_left = 2'b00;

    x0 = 354;
    for (int k = 0; k < 17; k++) begin
      d = (k < 9) ? 1 : 2;
      x0 += d;
      step(1, "ramp_to_3", x0, 100, 1, 2'b00, 2'b00);
    end
    step(1, "speed3", 382, 100, 1, 2'b00, 2'b00);
    move_right = 2'b00; move_left = 2'b01;
    step(1, "reverse", 381, 100, 1, 2'b00, 2'b00);
    x0 = 381;
    for (int k = 0; k < 8; k++) begin
      x0 -= 1;
      step(1, "left_ramp", x0, 100, 1, 2'b00, 2'b00);
    end
    step(1, "left_speed2", 371, 100, 1, 2'b00, 2'b00);
    pause = 1'b1;
    step(1, "pause_tick", 371, 100, 1, 2'b00, 2'b00);
    step(1, "paused_tick", 371, 100, 1, 2'b00, 2'b00);
    pause = 1'b0;
    step(0, "unpause", 371, 100, 1, 2'b00, 2'b00);
    step(1, "resume_speed1", 370, 100, 1, 2'b00, 2'b00);
    step(1, "resume_hold", 369, 100, 1, 2'b00, 2'b00);

    // Reset in RUN overrides a coincident tick and reloads the new x_init.
    reset = 1'b1;
    x_init = {10'd26, 10'd526};
    move_left = 2'b00; move_right = 2'b01;
    step(1, "reset_run", 526, 26, 0, 2'b00, 2'b00);
    reset = 1'b0; move_right = 2'b00;
    step(1, "idle2", 526, 26, 0, 2'b00, 2'b00);

    // Game 2: paddle 0 right, paddle 1 left, simultaneously; both clamp.
    move_right = 2'b01; move_left = 2'b10;
    step(1, "start2", 526, 26, 1, 2'b00, 2'b00);
    x0 = 526; x1 = 26;
    for (int k = 0; k < 24; k++) begin
      d = (k < 8) ? 1 : (k < 16) ? 2 : 3;
      x0 += d;
      x1 = (x1 < d) ? 0 : x1 - d;
      step(1, "dual_ramp", x0, x1, 1, (x1 == 0) ? 2'b10 : 2'b00, 2'b00);
    end
    step(1, "clamp_right", 576, 0, 1, 2'b10, 2'b01);
    paddle_width = {10'd700, 10'd64};
    move_right = 2'b11; move_left = 2'b00;
    step(1, "wide_pinned", 576, 0, 1, 2'b10, 2'b11);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
